// File: rtl/seq_alu.sv
// Registered N-bit ALU with a start/done handshake and a multi-cycle restoring divider.
// Optional build macro ALU_SAT_EN: ADD and MUL saturate to all-ones on carry-out.
module seq_alu #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic [3:0]   flags
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam int         CW     = $clog2(N + 1);

  typedef enum logic {IDLE, DIV} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           is_mod_reg, is_mod_next;
  logic [N-1:0]   divisor_reg, divisor_next;
  logic [N-1:0]   quo_reg, quo_next;
  logic [N-1:0]   rem_reg, rem_next;
  logic [N-1:0]   result_reg, result_next;
  logic [N-1:0]   hi_reg, hi_next;
  logic [3:0]     flags_reg, flags_next;
  logic           done_reg, done_next;

  // Single-cycle datapath, evaluated straight from the input operands.
  logic [N-1:0]   alu_res, alu_hi;
  logic [3:0]     alu_flags;
  logic           alu_div;
  logic [N:0]     sum;
  logic [2*N-1:0] prod;
  logic           fn, fz, fc, fv, no_z;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};

  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_div = 1'b0;
    fn      = 1'b0;
    fc      = 1'b0;
    fv      = 1'b0;
    no_z    = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[N-1:0];
        fc      = sum[N];
`ifdef ALU_SAT_EN
        if (sum[N]) alu_res = '1;
`endif
      end
      OP_SUB: begin
        if (a < b) begin
          alu_res = b - a;
          fn      = 1'b1;
        end else begin
          alu_res = a - b;
        end
      end
      OP_MUL: begin
        alu_res = prod[N-1:0];
        alu_hi  = prod[2*N-1:N];
        fc      = |prod[2*N-1:N];
`ifdef ALU_SAT_EN
        if (|prod[2*N-1:N]) alu_res = '1;
`endif
      end
      OP_DIV, OP_MOD: begin
        // Divide-by-zero completes at once with V set and Z suppressed.
        if (b == '0) begin
          fv   = 1'b1;
          no_z = 1'b1;
        end else begin
          alu_div = 1'b1;
        end
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: alu_res = (32'(b) >= N) ? '0 : (a << b);
      OP_SHR: alu_res = (32'(b) >= N) ? '0 : (a >> b);
      default: begin
        fv   = 1'b1;
        no_z = 1'b1;
      end
    endcase
    fz        = !no_z && (alu_res == '0);
    alu_flags = {fn, fz, fc, fv};
  end

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  logic [N:0]   rem_shift, diff;
  logic         step_ok;
  logic [N-1:0] rem_step, quo_step, div_res, div_hi;

  assign rem_shift = {rem_reg, quo_reg[N-1]};
  assign diff      = rem_shift - {1'b0, divisor_reg};
  assign step_ok   = !diff[N];
  assign rem_step  = step_ok ? diff[N-1:0] : rem_shift[N-1:0];
  assign quo_step  = {quo_reg[N-2:0], step_ok};
  assign div_res   = is_mod_reg ? rem_step : quo_step;
  assign div_hi    = is_mod_reg ? quo_step : rem_step;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    is_mod_next  = is_mod_reg;
    divisor_next = divisor_reg;
    quo_next     = quo_reg;
    rem_next     = rem_reg;
    result_next  = result_reg;
    hi_next      = hi_reg;
    flags_next   = flags_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (alu_div) begin
            state_next   = DIV;
            cnt_next     = CW'(N);
            is_mod_next  = (op == OP_MOD);
            divisor_next = b;
            quo_next     = a;
            rem_next     = '0;
          end else begin
            result_next = alu_res;
            hi_next     = alu_hi;
            flags_next  = alu_flags;
            done_next   = 1'b1;
          end
        end
      end
      DIV: begin
        quo_next = quo_step;
        rem_next = rem_step;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next  = IDLE;
          result_next = div_res;
          hi_next     = div_hi;
          flags_next  = {1'b0, div_res == '0, 2'b00};
          done_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      is_mod_reg  <= 1'b0;
      divisor_reg <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      result_reg  <= '0;
      hi_reg      <= '0;
      flags_reg   <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      is_mod_reg  <= is_mod_next;
      divisor_reg <= divisor_next;
      quo_reg     <= quo_next;
      rem_reg     <= rem_next;
      result_reg  <= result_next;
      hi_reg      <= hi_next;
      flags_reg   <= flags_next;
      done_reg    <= done_next;
    end
  end

  assign busy      = (state_reg == DIV);
  assign done      = done_reg;
  assign result    = result_reg;
  assign result_hi = hi_reg;
  assign flags     = flags_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (N=4): latency, busy window, results, flags, reset abort.
// Honours ALU_SAT_EN so the saturating build is checked against its own expectations.
module tb_seq_alu;
  localparam int N = 4;

`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   op;
  logic [N-1:0] a, b;
  logic         busy, done;
  logic [N-1:0] result, result_hi;
  logic [3:0]   flags;

  int checks = 0;
  int passes = 0;

  seq_alu #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Start one op, wait (bounded) for done, then check outputs, latency, busy window and pulse width.
  task automatic expect_op(input string tag, input logic [3:0] o, input logic [N-1:0] x,
                           input logic [N-1:0] y, input int exp_res, input int exp_hi,
                           input int exp_flags, input int exp_lat, input int exp_busy,
                           input bit inject);
    int lat, busy_cnt;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (inject && lat == 1) begin
        op = 4'd0; a = 4'd1; b = 4'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    $display("%s: op=%0d a=%0d b=%0d -> result=%0d hi=%0d flags=%b latency=%0d busy=%0d",
             tag, o, x, y, result, result_hi, flags, lat, busy_cnt);
    check({tag, "_done"},   32'(done),      32'd1);
    check({tag, "_result"}, 32'(result),    32'(exp_res));
    check({tag, "_hi"},     32'(result_hi), 32'(exp_hi));
    check({tag, "_flags"},  32'(flags),     32'(exp_flags));
    check({tag, "_lat"},    32'(lat),       32'(exp_lat));
    check({tag, "_busy"},   32'(busy_cnt),  32'(exp_busy));
    @(negedge clk);
    check({tag, "_pulse"},  32'(done),      32'd0);
    check({tag, "_hold"},   32'(result),    32'(exp_res));
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_result", 32'(result),    32'd0);
    check("rst_hi",     32'(result_hi), 32'd0);
    check("rst_flags",  32'(flags),     32'd0);
    rst = 1'b0;

    expect_op("add_9_8",  4'd0, 4'd9, 4'd8, SAT ? 15 : 1, 0, 4'b0010, 1, 0, 1'b0);
    expect_op("sub_3_5",  4'd1, 4'd3, 4'd5, 2, 0, 4'b1000, 1, 0, 1'b0);
    expect_op("sub_6_6",  4'd1, 4'd6, 4'd6, 0, 0, 4'b0100, 1, 0, 1'b0);
    expect_op("mul_7_5",  4'd2, 4'd7, 4'd5, SAT ? 15 : 3, 2, 4'b0010, 1, 0, 1'b0);

    // Abort a division with reset one cycle after it starts.
    @(negedge clk);
    op = 4'd3; a = 4'd15; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",   32'(busy),      32'd0);
    check("abort_done",   32'(done),      32'd0);
    check("abort_result", 32'(result),    32'd0);
    check("abort_hi",     32'(result_hi), 32'd0);
    check("abort_flags",  32'(flags),     32'd0);
    seen = 0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    $display("abort: div 15/2 reset mid-run, done pulses afterwards=%0d", seen);

    expect_op("add_2_2",  4'd0, 4'd2, 4'd2, 4, 0, 4'b0000, 1, 0, 1'b0);
    expect_op("div_13_4", 4'd3, 4'd13, 4'd4, 3, 1, 4'b0000, 5, 4, 1'b1);
    expect_op("div_5_0",  4'd3, 4'd5, 4'd0, 0, 0, 4'b0001, 1, 0, 1'b0);
    expect_op("mod_0_3",  4'd4, 4'd0, 4'd3, 0, 0, 4'b0100, 5, 4, 1'b0);
    expect_op("mod_13_4", 4'd4, 4'd13, 4'd4, 1, 3, 4'b0000, 5, 4, 1'b0);
    expect_op("div_15_1", 4'd3, 4'd15, 4'd1, 15, 0, 4'b0000, 5, 4, 1'b0);
    expect_op("and",      4'd5, 4'd12, 4'd10, 8, 0, 4'b0000, 1, 0, 1'b0);
    expect_op("or",       4'd6, 4'd12, 4'd3, 15, 0, 4'b0000, 1, 0, 1'b0);
    expect_op("xor",      4'd7, 4'd5, 4'd5, 0, 0, 4'b0100, 1, 0, 1'b0);
    expect_op("shl_9_1",  4'd8, 4'd9, 4'd1, 2, 0, 4'b0000, 1, 0, 1'b0);
    expect_op("shr_12_2", 4'd9, 4'd12, 4'd2, 3, 0, 4'b0000, 1, 0, 1'b0);
    expect_op("shr_8_4",  4'd9, 4'd8, 4'd4, 0, 0, 4'b0100, 1, 0, 1'b0);
    expect_op("illegal",  4'd12, 4'd3, 4'd3, 0, 0, 4'b0001, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
